tensor_stage_buffer: RTL and testbench
======================================

# tensor_stage_buffer

Operand/result staging buffer sitting directly downstream of the DMA controller. Captures memory read data into operand FIFO A or B when the DMA asserts `tensor_wen` with `set` = 0/1, and feeds the compute array's read ports. Accepts results from the compute array into FIFO X and drains them toward memory when the DMA asserts `tensor_ren` with `set` = 2. Tracks load completion via `finished_transfer` to tell the compute array when both operands are resident.

## Interface
- `DATAWIDTH`, 8, element width.
- `DEPTH_LOG2`, 4, log2 of entries per FIFO (16 each for A, B, X).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `mem_rdata` in DATAWIDTH: memory read data for the current DMA address.
- `tensor_wen` in 1: DMA push strobe for A/B.
- `tensor_ren` in 1: DMA pop strobe for X.
- `set` in 2: target select. 0 = A, 1 = B, 2 = X, 3 = none.
- `finished_transfer` in 1: DMA end-of-transfer pulse.
- `a_rd_en`, `b_rd_en` in 1: compute pops from A / B.
- `a_rdata`, `b_rdata` out DATAWIDTH: registered pop data.
- `a_rvalid`, `b_rvalid` out 1: pop data valid, one cycle after an accepted pop.
- `x_wr_en` in 1: compute push into X.
- `x_wdata` in DATAWIDTH: result data.
- `mem_wdata` out DATAWIDTH: X data toward memory.
- `mem_wen` out 1: `mem_wdata` valid.
- `ab_done` in 1: compute pulse that releases the loaded flags.
- `ab_ready` out 1: A and B both loaded.
- `a_count`, `b_count`, `x_count` out DEPTH_LOG2+1: occupancy.
- `a_full`, `b_full`, `x_full`, `a_empty`, `b_empty`, `x_empty` out 1: flags.
- `err` out 3: sticky {X, B, A} overflow/underflow. Present only with the macro; otherwise tied 0.

## Operation
- Three identical circular FIFOs. Each has a write pointer, a read pointer, and a count. Pointers are DEPTH_LOG2 bits and wrap modulo 2^DEPTH_LOG2. Count ranges 0..2^DEPTH_LOG2.
- **Push A:** `tensor_wen` && `set`==0 writes `mem_rdata`. **Push B:** same with `set`==1. `tensor_wen` with `set` = 2 or 3 is ignored.
- **Pop X:** `tensor_ren` && `set`==2. `tensor_ren` with `set` ≠ 2 is ignored.
- A and B are popped by `a_rd_en` / `b_rd_en`. X is pushed by `x_wr_en`.
- **Push when full:** accepted only if a pop on the same FIFO is accepted in the same cycle (count unchanged). Otherwise the push is dropped and the FIFO is untouched.
- **Pop when empty:** ignored, even if a push occurs in the same cycle (no fall-through). The push still proceeds.
- **Loaded flags:**
  - `finished_transfer` with `set`==0 sets `a_loaded`; with `set`==1 sets `b_loaded`.
  - `ab_ready` = `a_loaded` & `b_loaded`, registered.
  - `ab_done` clears both flags. If `ab_done` and `finished_transfer` occur in the same cycle, set wins for the flag named by `set`.
- `finished_transfer` with `set`==2 has no effect on the flags.

## Timing
- Reset values: all pointers, counts, `a_loaded`/`b_loaded`, `ab_ready`, `a_rvalid`, `b_rvalid`, `mem_wen`, and `err` are 0. `a_rdata`, `b_rdata`, `mem_wdata` are 0. `*_empty` = 1, `*_full` = 0.
- Push: data is written at the clock edge of the strobe. Count and flags update at the same edge, visible the next cycle.
- A/B pop: `*_rdata` and `*_rvalid` are registered 1 cycle after an accepted `*_rd_en`. `*_rvalid` is a single-cycle pulse per pop.
- X pop: `mem_wdata` and `mem_wen` are registered 1 cycle after an accepted `tensor_ren`. Back-to-back pops give a continuous `mem_wen`.
- `ab_ready` rises 1 cycle after the second `finished_transfer` and falls 1 cycle after `ab_done`.
- Reset mid-transfer empties all FIFOs immediately. Stored data is discarded; no pending `*_rvalid` or `mem_wen` is emitted.

## Configuration
- `TSB_OVF_CHECK_EN` defined: `err[i]` sets sticky on a dropped push (overflow) or an ignored pop (underflow) of FIFO i (0=A, 1=B, 2=X). Cleared only by `rst`.
- Undefined: overflow/underflow are silently dropped, `err` is constant 0, and no check logic is synthesized. FIFO behaviour is otherwise identical.

## Test plan
- **Fill A:** 16 `tensor_wen` pulses with `set`=0, `mem_rdata`=0x10..0x1F. Expect `a_count`=16, `a_full`=1. Then 16 `a_rd_en` → `a_rdata` 0x10..0x1F in order, each 1 cycle later, and `a_empty`=1 at the end.
- **Overflow A:** 17th push to full A with no pop → dropped, `a_count` stays 16. With macro, `err`=3'b001; without, `err`=0.
- **Loaded flags:** `finished_transfer` with `set`=0, later with `set`=1 → `ab_ready`=1 one cycle after the second. `ab_done` → `ab_ready`=0 next cycle.
- **Drain X:** push 0xA5, 0x5A, 0x3C via `x_wr_en`. Then 3 consecutive `tensor_ren` with `set`=2 → `mem_wen` high 3 cycles with `mem_wdata` 0xA5, 0x5A, 0x3C. A 4th pop is ignored (`err[2]` set with macro).
- **Full push+pop:** X full (16) with `x_wr_en` and `tensor_ren`/`set`=2 in the same cycle → `x_count` stays 16, pointers wrap, and the order is preserved over 32 further operations.
- **Mid-transfer reset:** `rst` after 5 pushes to B → `b_count`=0, `b_empty`=1, `ab_ready`=0. A following `b_rd_en` yields no `b_rvalid`.

Source files
------------

// File: rtl/tensor_stage_buffer_if.sv
// Bus bundle between the DMA / compute array and tensor_stage_buffer.
// master drives strobes and write data; slave is the staging buffer.
interface tensor_stage_buffer_if #(
    parameter int DATAWIDTH  = 8,
    parameter int DEPTH_LOG2 = 4
);
    logic [DATAWIDTH-1:0]  mem_rdata;
    logic                  tensor_wen;
    logic                  tensor_ren;
    logic [1:0]            set;
    logic                  finished_transfer;
    logic                  a_rd_en;
    logic                  b_rd_en;
    logic [DATAWIDTH-1:0]  a_rdata;
    logic [DATAWIDTH-1:0]  b_rdata;
    logic                  a_rvalid;
    logic                  b_rvalid;
    logic                  x_wr_en;
    logic [DATAWIDTH-1:0]  x_wdata;
    logic [DATAWIDTH-1:0]  mem_wdata;
    logic                  mem_wen;
    logic                  ab_done;
    logic                  ab_ready;
    logic [DEPTH_LOG2:0]   a_count;
    logic [DEPTH_LOG2:0]   b_count;
    logic [DEPTH_LOG2:0]   x_count;
    logic                  a_full;
    logic                  b_full;
    logic                  x_full;
    logic                  a_empty;
    logic                  b_empty;
    logic                  x_empty;
    logic [2:0]            err;

    modport slave (
        input  mem_rdata, tensor_wen, tensor_ren, set,
        input  finished_transfer, a_rd_en, b_rd_en,
        input  x_wr_en, x_wdata, ab_done,
        output a_rdata, b_rdata, a_rvalid, b_rvalid,
        output mem_wdata, mem_wen, ab_ready,
        output a_count, b_count, x_count,
        output a_full, b_full, x_full,
        output a_empty, b_empty, x_empty, err
    );

    modport master (
        output mem_rdata, tensor_wen, tensor_ren, set,
        output finished_transfer, a_rd_en, b_rd_en,
        output x_wr_en, x_wdata, ab_done,
        input  a_rdata, b_rdata, a_rvalid, b_rvalid,
        input  mem_wdata, mem_wen, ab_ready,
        input  a_count, b_count, x_count,
        input  a_full, b_full, x_full,
        input  a_empty, b_empty, x_empty, err
    );
endinterface

// File: rtl/tensor_stage_buffer.sv
// Operand FIFOs A/B and result FIFO X between DMA and compute array.
// Optional TSB_OVF_CHECK_EN adds sticky overflow/underflow flags on err.
module tensor_stage_buffer #(
    parameter int DATAWIDTH  = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    tensor_stage_buffer_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    typedef logic [DATAWIDTH-1:0]  data_t;
    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [CW-1:0]         cnt_t;

    localparam cnt_t FULL = cnt_t'(DEPTH);

    // index 0 = A, 1 = B, 2 = X
    data_t mem_q [3][DEPTH];
    ptr_t  wptr_q [3];
    ptr_t  wptr_d [3];
    ptr_t  rptr_q [3];
    ptr_t  rptr_d [3];
    cnt_t  cnt_q  [3];
    cnt_t  cnt_d  [3];
    data_t wdata  [3];

    logic [2:0] push;
    logic [2:0] pop;
    logic [2:0] push_ok;
    logic [2:0] pop_ok;

    data_t a_rdata_q, b_rdata_q, mem_wdata_q;
    logic  a_rvalid_q, b_rvalid_q, mem_wen_q;
    logic  a_loaded_q, a_loaded_d;
    logic  b_loaded_q, b_loaded_d;
    logic  ab_ready_q;

    always_comb begin
        push[0]  = bus.tensor_wen && (bus.set == 2'd0);
        push[1]  = bus.tensor_wen && (bus.set == 2'd1);
        push[2]  = bus.x_wr_en;
        pop[0]   = bus.a_rd_en;
        pop[1]   = bus.b_rd_en;
        pop[2]   = bus.tensor_ren && (bus.set == 2'd2);
        wdata[0] = bus.mem_rdata;
        wdata[1] = bus.mem_rdata;
        wdata[2] = bus.x_wdata;
        push_ok  = '0;
        pop_ok   = '0;
        for (int i = 0; i < 3; i++) begin
            pop_ok[i]  = pop[i] && (cnt_q[i] != '0);
            // full FIFO takes a push only alongside an accepted pop
            push_ok[i] = push[i] && ((cnt_q[i] != FULL) || pop_ok[i]);
            wptr_d[i]  = wptr_q[i] + ptr_t'(push_ok[i]);
            rptr_d[i]  = rptr_q[i] + ptr_t'(pop_ok[i]);
            cnt_d[i]   = cnt_q[i] + cnt_t'(push_ok[i])
                       - cnt_t'(pop_ok[i]);
        end
    end

    always_comb begin
        a_loaded_d = a_loaded_q;
        b_loaded_d = b_loaded_q;
        if (bus.ab_done) begin
            a_loaded_d = 1'b0;
            b_loaded_d = 1'b0;
        end
        if (bus.finished_transfer && (bus.set == 2'd0))
            a_loaded_d = 1'b1;
        if (bus.finished_transfer && (bus.set == 2'd1))
            b_loaded_d = 1'b1;
    end

    // storage is not reset; occupancy alone defines valid entries
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++)
            if (push_ok[i] && !rst)
                mem_q[i][wptr_q[i]] <= wdata[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            mem_wdata_q <= '0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            mem_wen_q   <= 1'b0;
            a_loaded_q  <= 1'b0;
            b_loaded_q  <= 1'b0;
            ab_ready_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                wptr_q[i] <= wptr_d[i];
                rptr_q[i] <= rptr_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            a_rvalid_q <= pop_ok[0];
            b_rvalid_q <= pop_ok[1];
            mem_wen_q  <= pop_ok[2];
            if (pop_ok[0])
                a_rdata_q <= mem_q[0][rptr_q[0]];
            if (pop_ok[1])
                b_rdata_q <= mem_q[1][rptr_q[1]];
            if (pop_ok[2])
                mem_wdata_q <= mem_q[2][rptr_q[2]];
            a_loaded_q <= a_loaded_d;
            b_loaded_q <= b_loaded_d;
            ab_ready_q <= a_loaded_d & b_loaded_d;
        end
    end

    assign bus.a_rdata   = a_rdata_q;
    assign bus.b_rdata   = b_rdata_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.a_rvalid  = a_rvalid_q;
    assign bus.b_rvalid  = b_rvalid_q;
    assign bus.mem_wen   = mem_wen_q;
    assign bus.ab_ready  = ab_ready_q;
    assign bus.a_count   = cnt_q[0];
    assign bus.b_count   = cnt_q[1];
    assign bus.x_count   = cnt_q[2];
    assign bus.a_full    = (cnt_q[0] == FULL);
    assign bus.b_full    = (cnt_q[1] == FULL);
    assign bus.x_full    = (cnt_q[2] == FULL);
    assign bus.a_empty   = (cnt_q[0] == '0);
    assign bus.b_empty   = (cnt_q[1] == '0);
    assign bus.x_empty   = (cnt_q[2] == '0);

`ifdef TSB_OVF_CHECK_EN
    logic [2:0] err_q;

    always_ff @(posedge clk) begin
        if (rst)
            err_q <= '0;
        else
            err_q <= err_q | (push & ~push_ok) | (pop & ~pop_ok);
    end

    assign bus.err = err_q;
`else
    assign bus.err = 3'b000;
`endif
endmodule

// File: tb/tb_tensor_stage_buffer.sv
// Scoreboard bench for tensor_stage_buffer: queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_tensor_stage_buffer;
    localparam int DW    = 8;
    localparam int DL    = 4;
    localparam int DEPTH = 16;
`ifdef TSB_OVF_CHECK_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tensor_stage_buffer_if #(.DATAWIDTH(DW), .DEPTH_LOG2(DL)) bus ();

    tensor_stage_buffer #(.DATAWIDTH(DW), .DEPTH_LOG2(DL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] qa [$];
    logic [7:0] qb [$];
    logic [7:0] qx [$];
    logic [7:0] expa [$];
    logic [7:0] expb [$];
    logic [7:0] expx [$];
    bit         la, lb;
    logic [2:0] errm;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.tensor_wen        = 1'b0;
        bus.tensor_ren        = 1'b0;
        bus.finished_transfer = 1'b0;
        bus.a_rd_en           = 1'b0;
        bus.b_rd_en           = 1'b0;
        bus.x_wr_en           = 1'b0;
        bus.ab_done           = 1'b0;
        bus.set               = 2'd3;
    endtask

    // Reference: FIFOs as queues, pop considered before push.
    task automatic model_step();
        bit ps, pp, okp, oks;
        if (rst) begin
            qa.delete(); qb.delete(); qx.delete();
            la = 0; lb = 0; errm = '0;
            return;
        end
        ps  = bus.tensor_wen && bus.set == 2'd0;
        pp  = bus.a_rd_en;
        okp = pp && qa.size() > 0;
        oks = ps && (qa.size() < DEPTH || okp);
        if (okp) expa.push_back(qa.pop_front());
        if (oks) qa.push_back(bus.mem_rdata);
        if (OVF && ((ps && !oks) || (pp && !okp))) errm[0] = 1'b1;

        ps  = bus.tensor_wen && bus.set == 2'd1;
        pp  = bus.b_rd_en;
        okp = pp && qb.size() > 0;
        oks = ps && (qb.size() < DEPTH || okp);
        if (okp) expb.push_back(qb.pop_front());
        if (oks) qb.push_back(bus.mem_rdata);
        if (OVF && ((ps && !oks) || (pp && !okp))) errm[1] = 1'b1;

        ps  = bus.x_wr_en;
        pp  = bus.tensor_ren && bus.set == 2'd2;
        okp = pp && qx.size() > 0;
        oks = ps && (qx.size() < DEPTH || okp);
        if (okp) expx.push_back(qx.pop_front());
        if (oks) qx.push_back(bus.x_wdata);
        if (OVF && ((ps && !oks) || (pp && !okp))) errm[2] = 1'b1;

        if (bus.ab_done) begin la = 0; lb = 0; end
        if (bus.finished_transfer && bus.set == 2'd0) la = 1;
        if (bus.finished_transfer && bus.set == 2'd1) lb = 1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("a_count", bus.a_count, qa.size());
        chk("b_count", bus.b_count, qb.size());
        chk("x_count", bus.x_count, qx.size());
        chk("a_full",  bus.a_full,  qa.size() == DEPTH);
        chk("b_full",  bus.b_full,  qb.size() == DEPTH);
        chk("x_full",  bus.x_full,  qx.size() == DEPTH);
        chk("a_empty", bus.a_empty, qa.size() == 0);
        chk("b_empty", bus.b_empty, qb.size() == 0);
        chk("x_empty", bus.x_empty, qx.size() == 0);
        chk("ab_ready", bus.ab_ready, la && lb);
        chk("err", bus.err, errm);
        idle();
    endtask

    // Monitor: every expected pop result must appear exactly one
    // cycle after it was issued, and nothing else may appear.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (bus.a_rvalid || expa.size() > 0) begin
                chk("a_rvalid", bus.a_rvalid, expa.size() > 0);
                if (bus.a_rvalid && expa.size() > 0)
                    chk("a_rdata", bus.a_rdata, expa[0]);
                if (expa.size() > 0) void'(expa.pop_front());
            end
            if (bus.b_rvalid || expb.size() > 0) begin
                chk("b_rvalid", bus.b_rvalid, expb.size() > 0);
                if (bus.b_rvalid && expb.size() > 0)
                    chk("b_rdata", bus.b_rdata, expb[0]);
                if (expb.size() > 0) void'(expb.pop_front());
            end
            if (bus.mem_wen || expx.size() > 0) begin
                chk("mem_wen", bus.mem_wen, expx.size() > 0);
                if (bus.mem_wen && expx.size() > 0)
                    chk("mem_wdata", bus.mem_wdata, expx[0]);
                if (expx.size() > 0) void'(expx.pop_front());
            end
        end
    end

    initial begin
        idle();
        bus.mem_rdata = '0;
        bus.x_wdata   = '0;
        la = 0; lb = 0; errm = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("a_rdata_rst",   bus.a_rdata,   8'h00);
        chk("b_rdata_rst",   bus.b_rdata,   8'h00);
        chk("mem_wdata_rst", bus.mem_wdata, 8'h00);
        chk("a_rvalid_rst",  bus.a_rvalid,  1'b0);
        chk("mem_wen_rst",   bus.mem_wen,   1'b0);

        // fill A, overflow, drain in order, then underflow
        for (int i = 0; i < 17; i++) begin
            bus.tensor_wen = 1'b1;
            bus.set        = 2'd0;
            bus.mem_rdata  = (i < 16) ? 8'(8'h10 + i) : 8'hEE;
            tick();
        end
        chk("a_count_full", bus.a_count, 5'd16);
        for (int i = 0; i < 17; i++) begin
            bus.a_rd_en = 1'b1;
            tick();
        end
        tick();

        // loaded flags
        bus.finished_transfer = 1'b1; bus.set = 2'd0; tick();
        tick();
        bus.finished_transfer = 1'b1; bus.set = 2'd1; tick();
        chk("ab_ready_up", bus.ab_ready, 1'b1);
        bus.ab_done = 1'b1; tick();
        chk("ab_ready_dn", bus.ab_ready, 1'b0);
        bus.finished_transfer = 1'b1; bus.set = 2'd2; tick();

        // drain X
        for (int i = 0; i < 3; i++) begin
            bus.x_wr_en = 1'b1;
            bus.x_wdata = (i == 0) ? 8'hA5 : (i == 1) ? 8'h5A : 8'h3C;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            bus.tensor_ren = 1'b1; bus.set = 2'd2; tick();
        end
        tick();

        // X full with simultaneous push and pop, pointers wrap
        for (int i = 0; i < DEPTH; i++) begin
            bus.x_wr_en = 1'b1; bus.x_wdata = 8'($urandom); tick();
        end
        for (int i = 0; i < 32; i++) begin
            bus.x_wr_en    = 1'b1;
            bus.x_wdata    = 8'($urandom);
            bus.tensor_ren = 1'b1;
            bus.set        = 2'd2;
            tick();
        end
        chk("x_count_wrap", bus.x_count, 5'd16);
        for (int i = 0; i < DEPTH; i++) begin
            bus.tensor_ren = 1'b1; bus.set = 2'd2; tick();
        end
        tick();

        // mid-transfer reset
        bus.finished_transfer = 1'b1; bus.set = 2'd0; tick();
        bus.finished_transfer = 1'b1; bus.set = 2'd1; tick();
        for (int i = 0; i < 5; i++) begin
            bus.tensor_wen = 1'b1; bus.set = 2'd1;
            bus.mem_rdata  = 8'($urandom); tick();
        end
        rst = 1'b1; bus.b_rd_en = 1'b1; tick();
        rst = 1'b0;
        chk("b_count_rst", bus.b_count, 5'd0);
        chk("b_empty_rst", bus.b_empty, 1'b1);
        chk("ab_ready_rst", bus.ab_ready, 1'b0);
        bus.b_rd_en = 1'b1; tick();
        chk("b_rvalid_rst", bus.b_rvalid, 1'b0);
        tick();

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            bus.tensor_wen        = 1'($urandom);
            bus.tensor_ren        = 1'($urandom);
            bus.set               = 2'($urandom_range(0, 3));
            bus.mem_rdata         = 8'($urandom);
            bus.a_rd_en           = ($urandom_range(0, 2) == 0);
            bus.b_rd_en           = ($urandom_range(0, 2) == 0);
            bus.x_wr_en           = 1'($urandom);
            bus.x_wdata           = 8'($urandom);
            bus.finished_transfer = ($urandom_range(0, 5) == 0);
            bus.ab_done           = ($urandom_range(0, 7) == 0);
            rst                   = ($urandom_range(0, 150) == 0);
            tick();
            rst = 1'b0;
        end
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
